mem_block_mover: RTL
====================

Name: mem_block_mover

Overview:
- Initiator-side engine for the single-port data memory (one shared address, write enable, write data, combinational read data).
- Executes block FILL and block COPY commands by driving the memory port itself, so the CPU core does not spend cycles on bulk moves.
- Sits between the control path (command/start) and the data memory port; owns that port while busy.

Parameters:
- WIDTH, 8, data and address width; memory depth is 2**WIDTH words.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  command strobe; accepted only in IDLE.
- op  input  1  0 = FILL, 1 = COPY; sampled with start.
- src  input  WIDTH  COPY source base address; sampled with start.
- dst  input  WIDTH  destination base address; sampled with start.
- len  input  WIDTH  word count; 0 means no transfer; sampled with start.
- pattern  input  WIDTH  FILL value; sampled with start.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse on completion.
- mem_en  output  1  memory write enable.
- mem_addr  output  WIDTH  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory read data; combinational from mem_addr.

Behaviour:
- States: IDLE, RD, WR, FIN. All outputs are registered or decoded from registered state and counters only.
- Reset (rst_n low at a posedge): state=IDLE; busy=0, done=0, mem_en=0, mem_addr=0, mem_wdata=0; internal index and holding register cleared. Reset in any state aborts the operation with no further writes. A write that was issued on the reset edge itself is allowed to complete.
- IDLE: mem_en=0. When start=1, latch op/src/dst/len/pattern and clear index i=0.
  - len=0: go to FIN.
  - op=FILL: go to WR.
  - op=COPY: go to RD.
- RD (COPY only):
  - mem_addr=src+i, mem_en=0.
  - On the clock edge, capture mem_rdata into the holding register, then go to WR.
- WR:
  - mem_addr=dst+i, mem_en=1.
  - mem_wdata = pattern for FILL, holding register for COPY.
  - On the edge, i=i+1.
  - If i+1==len, go to FIN. Otherwise go to RD for COPY, or stay in WR for FILL.
- FIN: done=1 for exactly one cycle, mem_en=0, then return to IDLE.
- busy=1 in RD, WR and FIN; busy=0 in IDLE.
- Throughput:
  - FILL writes one word per cycle, so len words take len+1 cycles after acceptance including FIN.
  - COPY takes 2 cycles per word, so 2*len+1 cycles.
- Address arithmetic is modulo 2**WIDTH: base+i wraps silently, e.g. dst=0xFE, len=4 writes 0xFE, 0xFF, 0x00, 0x01.
- Overlap: COPY is strictly ascending and read-then-write per word.
  - With dst>src and the ranges overlapping, data propagates forward. This is the defined behaviour, not an error.
- start while busy is ignored; the latched command is unchanged and there is no queueing.
- start in the same cycle as FIN is ignored; the command is accepted only from IDLE on the next cycle.
- Input changes on op/src/dst/len/pattern while busy have no effect.

Optional Feature:
- Macro MEM_BLOCK_MOVER_SUM_EN.
- Defined:
  - Adds output port sum (WIDTH): the modulo-2**WIDTH sum of every mem_wdata value written by the current command.
  - sum is cleared on command acceptance and on reset, and accumulates on each WR cycle.
  - sum is valid and stable from the done cycle until the next acceptance.
- Undefined: no sum port, no accumulator logic. All other behaviour is identical.

Test Plan:
- Reset, then FILL dst=0x10 len=4 pattern=0xA5 -> mem_en high 4 consecutive cycles at 0x10..0x13 with data 0xA5, done pulses in the cycle after, busy low next cycle; sum=0x94 when MEM_BLOCK_MOVER_SUM_EN is defined.
- Preload 0x20..0x22 = 0x01, 0x02, 0x03; COPY src=0x20 dst=0x40 len=3 -> writes at 0x40..0x42 of 0x01, 0x02, 0x03 on alternate cycles, done 7 cycles after acceptance.
- FILL dst=0xFE len=4 pattern=0x3C -> writes at 0xFE, 0xFF, 0x00, 0x01; 0x02 untouched.
- len=0 with either op -> no mem_en assertion, done pulse the cycle after acceptance.
- During a COPY with len=8, assert start with different args -> ignored, the original transfer completes unchanged; rst_n low after 3 words -> only 3 destination words modified, outputs at reset values.
- Overlapping COPY src=0x30 dst=0x31 len=3 with 0x30=0x77 -> 0x31..0x33 all read back 0x77.

Source files
------------

// File: rtl/mem_block_mover.sv
// Block FILL/COPY engine that owns a single-port data memory while busy.
// Optional running write-data checksum on port `sum` when MEM_BLOCK_MOVER_SUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; memory port quiet
// RD    | COPY: address src+i, capture read data into hold
// WR    | write word i at dst+i, advance index
// FIN   | one-cycle done pulse, back to IDLE
module mem_block_mover #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] len,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef MEM_BLOCK_MOVER_SUM_EN
  ,
  output logic [WIDTH-1:0] sum
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t           state, state_nx;
  logic             op_q;
  logic [WIDTH-1:0] src_q, dst_q, len_q, pat_q;
  logic [WIDTH-1:0] idx, hold;
  logic [WIDTH-1:0] idx_inc;

  assign idx_inc = idx + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      pat_q <= '0;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            pat_q <= pattern;
            idx   <= '0;
          end
        end
        RD:      hold <= mem_rdata;
        WR:      idx  <= idx_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)   state_nx = FIN;
          else if (op)     state_nx = RD;
          else             state_nx = WR;
        end
      end
      RD: state_nx = WR;
      WR: begin
        if (idx_inc == len_q) state_nx = FIN;
        else if (op_q)        state_nx = RD;
        else                  state_nx = WR;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port outputs decode purely from registered state, index and latched command.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    case (state)
      RD: mem_addr = src_q + idx;
      WR: begin
        mem_en    = 1'b1;
        mem_addr  = dst_q + idx;
        mem_wdata = op_q ? hold : pat_q;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_BLOCK_MOVER_SUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                   sum <= '0;
    else if (state == IDLE && start) sum <= '0;
    else if (state == WR)         sum <= sum + mem_wdata;
  end
`endif

endmodule
